c2_line_master: RTL

Initiator side of the C2 line bus, placed at the bottom of the cache controller. Takes one whole-line read or write request from the controller, drives the command/address/data beats onto the shared tri-state C2 bus, releases the bus, waits for `C2_RESPONSE` from the memory responder, and collects the returned beats. Returns the line (reads), an error flag on timeout, and the measured response latency in cycles.

---
 rtl/c2_bus_pkg.sv | 22 ++
 rtl/c2_line_master.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/c2_bus_pkg.sv
// Shared C2 line-bus definitions: command encodings, byte width and default sizes.
// Imported by every block that sits on the C2 bus.
package c2_bus_pkg;

    typedef enum logic [1:0] {
        C2_NOP        = 2'd0,
        C2_READ_LINE  = 2'd1,
        C2_WRITE_LINE = 2'd2,
        C2_RESPONSE   = 2'd3
    } c2_cmd_t;

    localparam int BITS_IN_BYTE  = 8;
    localparam int C2_LINE_BYTES = 16;
    localparam int C2_BUS_BYTES  = 2;
    localparam int C2_ADDR_BYTES = 2;
    localparam int C2_TIMEOUT    = 1024;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/c2_line_master.sv
// C2 line-bus initiator: one whole-line read or write per request,
// tri-state command/data beats, response wait with timeout and latency count.
module c2_line_master
    import c2_bus_pkg::*;
#(
    parameter int LINE_BYTES = C2_LINE_BYTES,
    parameter int BUS_BYTES  = C2_BUS_BYTES,
    parameter int ADDR_BYTES = C2_ADDR_BYTES,
    parameter int TIMEOUT    = C2_TIMEOUT
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_write,
    input  logic [BITS_IN_BYTE*ADDR_BYTES-1:0] req_addr,
    input  logic [BITS_IN_BYTE*LINE_BYTES-1:0] req_wdata,
    output logic                               resp_valid,
    output logic [BITS_IN_BYTE*LINE_BYTES-1:0] resp_rdata,
    output logic                               resp_error,
    output logic [15:0]                        resp_latency,
    output logic [BITS_IN_BYTE*ADDR_BYTES-1:0] c2_addr,
    inout  logic [BITS_IN_BYTE*BUS_BYTES-1:0]  c2_data,
    inout  logic [1:0]                         c2_cmd
);

    localparam int BEATS  = LINE_BYTES / BUS_BYTES;
    localparam int LINE_W = BITS_IN_BYTE * LINE_BYTES;
    localparam int BUS_W  = BITS_IN_BYTE * BUS_BYTES;
    localparam int ADDR_W = BITS_IN_BYTE * ADDR_BYTES;
    localparam int BI_W   = $clog2(BEATS);
    localparam int WT_W   = $clog2(TIMEOUT + 1);

    localparam logic [BI_W-1:0] LAST_BEAT = BI_W'(BEATS - 1);
    localparam logic [WT_W-1:0] LAST_WAIT = WT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RCMD,
        S_WBURST,
        S_WAIT,
        S_RBURST,
        S_DONE
    } state_t;

    state_t              r_state;
    logic                r_own;
    c2_cmd_t             r_cmd;
    logic [BUS_W-1:0]    r_data;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [LINE_W-1:0]   r_wline;
    logic [LINE_W-1:0]   r_rline;
    logic [BI_W-1:0]     r_beat;
    logic [WT_W-1:0]     r_wait;
    logic [15:0]         r_lat;
    logic                r_ready;
    logic                r_valid;
    logic                r_error;

    logic                w_rsp;

    // Only a clean RESPONSE code counts; a floating or contended bus does not.
    assign w_rsp = (c2_cmd === C2_RESPONSE);

    assign c2_cmd  = r_own ? r_cmd  : 2'bzz;
    assign c2_data = r_own ? r_data : {BUS_W{1'bz}};
    assign c2_addr = r_addr;

    assign req_ready    = r_ready;
    assign resp_valid   = r_valid;
    assign resp_rdata   = r_rline;
    assign resp_error   = r_error;
    assign resp_latency = r_lat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_own   <= 1'b1;
            r_cmd   <= C2_NOP;
            r_data  <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wline <= '0;
            r_rline <= '0;
            r_beat  <= '0;
            r_wait  <= '0;
            r_lat   <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid && r_ready) begin
                        r_addr  <= req_addr;
                        r_write <= req_write;
                        r_lat   <= '0;
                        r_error <= 1'b0;
                        r_rline <= '0;
                        r_beat  <= '0;
                        r_ready <= 1'b0;
                        if (req_write) begin
                            r_state <= S_WBURST;
                            r_cmd   <= C2_WRITE_LINE;
                            r_data  <= req_wdata[BUS_W-1:0];
                            r_wline <= req_wdata >> BUS_W;
                        end else begin
                            r_state <= S_RCMD;
                            r_cmd   <= C2_READ_LINE;
                            r_data  <= '0;
                        end
                    end
                end
                S_RCMD: begin
                    r_lat   <= sat_inc16(r_lat);
                    r_own   <= 1'b0;
                    r_cmd   <= C2_NOP;
                    r_wait  <= '0;
                    r_state <= S_WAIT;
                end
                S_WBURST: begin
                    r_lat <= sat_inc16(r_lat);
                    if (r_beat == LAST_BEAT) begin
                        r_own   <= 1'b0;
                        r_cmd   <= C2_NOP;
                        r_data  <= '0;
                        r_wait  <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_beat  <= r_beat + 1'b1;
                        r_data  <= r_wline[BUS_W-1:0];
                        r_wline <= r_wline >> BUS_W;
                    end
                end
                S_WAIT: begin
                    r_lat <= sat_inc16(r_lat);
                    if (w_rsp) begin
                        if (r_write) begin
                            r_valid <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_rline <= {c2_data, r_rline[LINE_W-1:BUS_W]};
                            r_beat  <= BI_W'(1);
                            r_state <= S_RBURST;
                        end
                    end else if (r_wait == LAST_WAIT) begin
                        r_valid <= 1'b1;
                        r_error <= 1'b1;
                        r_rline <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_RBURST: begin
                    // Beats shift in from the top so beat 0 lands at the low bytes.
                    r_rline <= {c2_data, r_rline[LINE_W-1:BUS_W]};
                    r_beat  <= r_beat + 1'b1;
                    if (r_beat == LAST_BEAT) begin
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_own   <= 1'b1;
                    r_cmd   <= C2_NOP;
                    r_data  <= '0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
